tree_walker: RTL and testbench

Sequential hardware walker for the message-hierarchy tree. Holds a runtime-loadable node table of (parent, identifier) pairs and a path stack. It accepts advance/rewind commands from the message decoder, returning the matched child node, the new level and an error code. It is the parametrised, clocked successor to the package-level tree functions: table depth, stack depth and identifier width are configurable, and it adds bounds checking and load-time configuration.

---
 rtl/tree_walker_pkg.sv | 27 ++
 rtl/tree_walker_path_stack.sv | 65 ++++++
 rtl/tree_walker.sv | 209 ++++++++++++++++++++
 tb/tb_tree_walker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_walker_pkg.sv
// tree_walker_pkg: shared types for the message-hierarchy tree walker.
//   op_e    - command opcode (ADVANCE / REWIND)
//   err_e   - response error code
//   state_e - walker FSM states
// The table entry struct depends on module parameters, so tree_walker
// declares it locally as entry_t {valid, parent, id}.
package tree_walker_pkg;

   typedef enum logic {
      OP_ADVANCE = 1'b0,
      OP_REWIND  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ERR_OK        = 2'd0,
      ERR_NOMATCH   = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_UNDERFLOW = 2'd3
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/tree_walker_path_stack.sv
// tree_walker_path_stack: path stack of visited nodes, one slot per level.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_node   - append push_node at the current level (ignored when full)
//   pop               - remove the top slot, clearing it (ignored when empty)
//   level             - number of occupied slots
//   top_node          - node at the top slot (0 when empty)
//   below_node        - node one slot under the top (0 when level < 2)
//   full, empty       - level == MAX_DEPTH / level == 0
//   path              - flattened slots, slot j at [j*ADDR_W +: ADDR_W]
module tree_walker_path_stack #(
   parameter int unsigned MAX_DEPTH = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned LEVEL_W   = $clog2(MAX_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [ADDR_W-1:0]             push_node,
   input  logic                          pop,
   output logic [LEVEL_W-1:0]            level,
   output logic [ADDR_W-1:0]             top_node,
   output logic [ADDR_W-1:0]             below_node,
   output logic                          full,
   output logic                          empty,
   output logic [MAX_DEPTH*ADDR_W-1:0]   path
);

   logic [ADDR_W-1:0] slot [MAX_DEPTH];

   assign full  = (level == LEVEL_W'(MAX_DEPTH));
   assign empty = (level == '0);

   // Popped slots are zeroed, so unused slots always read 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
         for (int j = 0; j < MAX_DEPTH; j++) slot[j] <= '0;
      end else if (push && !full) begin
         for (int j = 0; j < MAX_DEPTH; j++)
            if (LEVEL_W'(j) == level) slot[j] <= push_node;
         level <= level + LEVEL_W'(1);
      end else if (pop && !empty) begin
         for (int j = 0; j < MAX_DEPTH; j++)
            if (LEVEL_W'(j + 1) == level) slot[j] <= '0;
         level <= level - LEVEL_W'(1);
      end
   end

   // Top and next-to-top slot selection.
   always_comb begin
      top_node   = '0;
      below_node = '0;
      for (int j = 0; j < MAX_DEPTH; j++) begin
         if (LEVEL_W'(j + 1) == level) top_node   = slot[j];
         if (LEVEL_W'(j + 2) == level) below_node = slot[j];
      end
   end

   always_comb begin
      path = '0;
      for (int j = 0; j < MAX_DEPTH; j++) path[j*ADDR_W +: ADDR_W] = slot[j];
   end

endmodule

// File: rtl/tree_walker.sv
// tree_walker: walks the message-hierarchy tree one level per command.
// Holds a loadable node table of (parent, id) entries and a path stack.
// ADVANCE descends to the lowest-index child of cur_node whose id matches;
// REWIND climbs one level.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   tbl_we/tbl_addr/tbl_parent/tbl_id - table entry write (IDLE only, addr 0 ignored)
//   tbl_clr                        - clear all valid bits (IDLE only)
//   cmd_valid/cmd_ready/cmd_op/cmd_id - command handshake
//   rsp_valid/rsp_err/rsp_node     - one-cycle response pulse
//   cur_node/cur_level/path        - walker state
// Build option: define TREE_WALKER_PARALLEL_EN to compare all entries in the
// accept cycle instead of scanning one entry per cycle.
module tree_walker
   import tree_walker_pkg::*;
#(
   parameter int unsigned NUM_NODES = 16,
   parameter int unsigned MAX_DEPTH = 8,
   parameter int unsigned ID_W      = 8,
   localparam int unsigned ADDR_W   = $clog2(NUM_NODES),
   localparam int unsigned LEVEL_W  = $clog2(MAX_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tbl_we,
   input  logic [ADDR_W-1:0]           tbl_addr,
   input  logic [ADDR_W-1:0]           tbl_parent,
   input  logic [ID_W-1:0]             tbl_id,
   input  logic                        tbl_clr,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_op,
   input  logic [ID_W-1:0]             cmd_id,
   output logic                        rsp_valid,
   output logic [1:0]                  rsp_err,
   output logic [ADDR_W-1:0]           rsp_node,
   output logic [ADDR_W-1:0]           cur_node,
   output logic [LEVEL_W-1:0]          cur_level,
   output logic [MAX_DEPTH*ADDR_W-1:0] path
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] parent;
      logic [ID_W-1:0]   id;
   } entry_t;

   state_e            state;
   entry_t            tbl [NUM_NODES];
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_node;
   logic [ADDR_W-1:0] below_node;
   logic              full;
   logic              empty;

   assign cmd_ready = (state == ST_IDLE) && !rst;

   tree_walker_path_stack #(
      .MAX_DEPTH (MAX_DEPTH),
      .ADDR_W    (ADDR_W),
      .LEVEL_W   (LEVEL_W)
   ) u_stack (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_node  (push_node),
      .pop        (pop),
      .level      (cur_level),
      .top_node   (cur_node),
      .below_node (below_node),
      .full       (full),
      .empty      (empty),
      .path       (path)
   );

`ifdef TREE_WALKER_PARALLEL_EN
   entry_t            eff [NUM_NODES];
   logic              par_hit;
   logic [ADDR_W-1:0] par_idx;

   // Table as it will look after this cycle's clear/write, so a write that
   // accompanies an accepted command is already visible to the match.
   always_comb begin
      eff[0] = tbl[0];
      for (int i = 1; i < NUM_NODES; i++) begin
         eff[i] = tbl[i];
         if (tbl_clr) eff[i].valid = 1'b0;
         if (tbl_we && tbl_addr == ADDR_W'(i)) eff[i] = '{1'b1, tbl_parent, tbl_id};
      end
   end

   // Lowest-index priority encoder: descending loop lets low indices win.
   always_comb begin
      par_hit = 1'b0;
      par_idx = '0;
      for (int i = NUM_NODES - 1; i >= 1; i--) begin
         if (eff[i].valid && eff[i].parent == cur_node && eff[i].id == cmd_id) begin
            par_hit = 1'b1;
            par_idx = ADDR_W'(i);
         end
      end
   end
`else
   logic [ADDR_W-1:0] idx;
   logic [ID_W-1:0]   id_q;
   logic              seq_hit;

   assign seq_hit = tbl[idx].valid && (tbl[idx].parent == cur_node) && (tbl[idx].id == id_q);
`endif

   // Stack strobes fire on the edge that enters RESP.
   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      push_node = '0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_op == OP_REWIND && !empty) pop = 1'b1;
`ifdef TREE_WALKER_PARALLEL_EN
            if (cmd_valid && cmd_op == OP_ADVANCE && !full && par_hit) begin
               push      = 1'b1;
               push_node = par_idx;
            end
`endif
         end
`ifndef TREE_WALKER_PARALLEL_EN
         ST_SEARCH: begin
            if (seq_hit) begin
               push      = 1'b1;
               push_node = idx;
            end
         end
`endif
         default: ;
      endcase
   end

   // Walker FSM, table storage and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rsp_valid <= 1'b0;
         rsp_err   <= ERR_OK;
         rsp_node  <= '0;
         for (int i = 0; i < NUM_NODES; i++) tbl[i] <= '0;
`ifndef TREE_WALKER_PARALLEL_EN
         idx  <= '0;
         id_q <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tbl_clr)
                  for (int i = 0; i < NUM_NODES; i++) tbl[i].valid <= 1'b0;
               if (tbl_we && tbl_addr != '0)
                  tbl[tbl_addr] <= '{1'b1, tbl_parent, tbl_id};
               if (cmd_valid) begin
                  if (cmd_op == OP_REWIND) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= empty ? ERR_UNDERFLOW : ERR_OK;
                     rsp_node  <= empty ? cur_node : below_node;
                  end else if (full) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= ERR_OVERFLOW;
                     rsp_node  <= cur_node;
                  end else begin
`ifdef TREE_WALKER_PARALLEL_EN
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= par_hit ? ERR_OK : ERR_NOMATCH;
                     rsp_node  <= par_hit ? par_idx : cur_node;
`else
                     state <= ST_SEARCH;
                     idx   <= ADDR_W'(1);
                     id_q  <= cmd_id;
`endif
                  end
               end
            end
            ST_SEARCH: begin
`ifndef TREE_WALKER_PARALLEL_EN
               if (seq_hit) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_OK;
                  rsp_node  <= idx;
               end else if (idx == ADDR_W'(NUM_NODES - 1)) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_NOMATCH;
                  rsp_node  <= cur_node;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
`else
               state <= ST_IDLE;
`endif
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tree_walker.sv
// tb_tree_walker: directed and randomized checks of tree_walker against a
// table/queue model of the tree walk.
module tb_tree_walker;
   import tree_walker_pkg::*;

   localparam int unsigned NN = 16;
   localparam int unsigned MD = 8;
   localparam int unsigned IW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tbl_we = 1'b0;
   logic [AW-1:0] tbl_addr = '0;
   logic [AW-1:0] tbl_parent = '0;
   logic [IW-1:0] tbl_id = '0;
   logic          tbl_clr = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_op = 1'b0;
   logic [IW-1:0] cmd_id = '0;
   logic          rsp_valid;
   logic [1:0]    rsp_err;
   logic [AW-1:0] rsp_node;
   logic [AW-1:0] cur_node;
   logic [LW-1:0] cur_level;
   logic [MD*AW-1:0] path;

   tree_walker #(.NUM_NODES(NN), .MAX_DEPTH(MD), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_parent(tbl_parent), .tbl_id(tbl_id),
      .tbl_clr(tbl_clr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_node(rsp_node),
      .cur_node(cur_node), .cur_level(cur_level), .path(path)
   );

   always #5 clk = ~clk;

   // Reference model: node table plus the walked path as a queue of nodes.
   bit   m_valid [NN];
   int   m_par   [NN];
   int   m_id    [NN];
   int   path_q  [$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_node();
      return (path_q.size() == 0) ? 0 : path_q[path_q.size() - 1];
   endfunction

   function automatic logic [MD*AW-1:0] m_path();
      logic [MD*AW-1:0] v = '0;
      for (int j = 0; j < path_q.size(); j++) v[j*AW +: AW] = AW'(path_q[j]);
      return v;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < NN; i++) m_valid[i] = 1'b0;
   endtask

   task automatic tbl_write(input int a, input int p, input int id);
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = AW'(a); tbl_parent = AW'(p); tbl_id = IW'(id);
      @(negedge clk);
      tbl_we = 1'b0;
      if (a != 0) begin m_valid[a] = 1'b1; m_par[a] = p; m_id[a] = id; end
   endtask

   task automatic tbl_clear();
      @(negedge clk);
      tbl_clr = 1'b1;
      @(negedge clk);
      tbl_clr = 1'b0;
      m_clear();
   endtask

   // One command with optional same-cycle table write; checks latency,
   // response and walker state against the model.
   task automatic do_cmd(input string tag, input bit op, input int id,
                         input bit we, input int wa, input int wp, input int wid);
      int         exp_lat;
      int         n;
      int         hit;
      logic [1:0] exp_err;
      @(negedge clk);
      chk({tag, "/ready"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_id = IW'(id);
      tbl_we = we; tbl_addr = AW'(wa); tbl_parent = AW'(wp); tbl_id = IW'(wid);
      if (we && wa != 0) begin m_valid[wa] = 1'b1; m_par[wa] = wp; m_id[wa] = wid; end
      exp_lat = 1;
      if (op == 1'b0) begin
         if (path_q.size() == MD) begin
            exp_err = ERR_OVERFLOW;
         end else begin
            hit = 0;
            for (int k = 1; k < NN; k++)
               if (m_valid[k] && m_par[k] == m_node() && m_id[k] == id) begin
                  hit = k;
                  break;
               end
            exp_err = (hit != 0) ? ERR_OK : ERR_NOMATCH;
`ifndef TREE_WALKER_PARALLEL_EN
            exp_lat = (hit != 0) ? hit + 1 : NN;
`endif
            if (hit != 0) path_q.push_back(hit);
         end
      end else begin
         if (path_q.size() == 0) exp_err = ERR_UNDERFLOW;
         else begin exp_err = ERR_OK; void'(path_q.pop_back()); end
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; tbl_we = 1'b0;
      n = 1;
      while (!rsp_valid && n < 2 * NN) begin @(negedge clk); n++; end
      chk({tag, "/latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "/err"}, 64'(rsp_err), 64'(exp_err));
      chk({tag, "/rsp_node"}, 64'(rsp_node), 64'(m_node()));
      chk({tag, "/cur_node"}, 64'(cur_node), 64'(m_node()));
      chk({tag, "/cur_level"}, 64'(cur_level), 64'(path_q.size()));
      chk({tag, "/path"}, 64'(path), 64'(m_path()));
      @(negedge clk);
      chk({tag, "/pulse"}, 64'(rsp_valid), 64'd0);
      chk({tag, "/ready_again"}, 64'(cmd_ready), 64'd1);
   endtask

   task automatic adv(input string tag, input int id);
      do_cmd(tag, 1'b0, id, 1'b0, 0, 0, 0);
   endtask

   task automatic rew(input string tag);
      do_cmd(tag, 1'b1, 0, 1'b0, 0, 0, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "/rsp_err"}, 64'(rsp_err), 64'd0);
      chk({tag, "/rsp_node"}, 64'(rsp_node), 64'd0);
      chk({tag, "/cur_node"}, 64'(cur_node), 64'd0);
      chk({tag, "/cur_level"}, 64'(cur_level), 64'd0);
      chk({tag, "/path"}, 64'(path), 64'd0);
   endtask

   initial begin
      int seen;
      m_clear();

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset/ready_in_rst", 64'(cmd_ready), 64'd0);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Empty table
      adv("empty", 8'h05);

      // Two-level walk
      tbl_write(1, 0, 8'h05);
      tbl_write(3, 1, 8'h07);
      adv("walk1", 8'h05);
      adv("walk2", 8'h07);
      chk("walk/path_slots", 64'(path), 64'h31);
      rew("rew1");
      rew("rew0");
      rew("underflow");

      // Duplicate entries: lowest index wins
      tbl_write(2, 0, 8'h09);
      tbl_write(6, 0, 8'h09);
      adv("dup", 8'h09);
      chk("dup/node", 64'(rsp_node), 64'd2);
      rew("dup_rew");

      // Fill the path stack, then overflow and drain
      tbl_clear();
      for (int k = 1; k <= int'(MD); k++) tbl_write(k, k - 1, 8'h10 + k);
      for (int k = 1; k <= int'(MD); k++) adv("chain", 8'h10 + k);
      adv("overflow", 8'h19);
      for (int k = 0; k < int'(MD); k++) rew("drain");
      rew("underflow2");

      // Write accompanying an accepted command is seen by that search
      do_cmd("same_cycle_wr", 1'b0, 8'h33, 1'b1, 12, 0, 8'h33);
      rew("same_cycle_rew");

      // Randomized walk over a random table
      tbl_clear();
      for (int i = 0; i < 12; i++)
         tbl_write($urandom_range(1, NN - 1), $urandom_range(0, NN - 1), $urandom_range(1, 3));
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 6) begin
            if ($urandom_range(0, 9) == 0)
               do_cmd("rand_adv_wr", 1'b0, $urandom_range(1, 3), 1'b1,
                      $urandom_range(0, NN - 1), $urandom_range(0, NN - 1), $urandom_range(1, 3));
            else
               adv("rand_adv", $urandom_range(1, 3));
         end else begin
            rew("rand_rew");
         end
      end

      // Reset while busy aborts with no response and clears everything
      tbl_clear();
      path_q.delete();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tbl_write(1, 0, 8'h05);
      adv("pre_rst", 8'h05);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_id = 8'hEE;
      @(negedge clk);
      cmd_valid = 1'b0;
`ifndef TREE_WALKER_PARALLEL_EN
      repeat (3) @(negedge clk);
`else
      @(negedge clk);
`endif
      rst = 1'b1;
      @(negedge clk);
      chk("midrst/ready", 64'(cmd_ready), 64'd0);
      chk_reset_outputs("midrst");
      rst = 1'b0;
      m_clear();
      path_q.delete();
      seen = 0;
      for (int i = 0; i < int'(NN) + 4; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("midrst/no_rsp", 64'(seen), 64'd0);
      adv("post_rst", 8'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
